imm_gen_stage: RTL

Parametrised, registered immediate generator for the decode stage of the 5-stage pipeline. It extracts and sign-extends the immediate from a full 32-bit instruction for XLEN = 32 or 64, adds CSR zimm and RV64 6-bit shamt formats, and precomputes the PC-relative target `pc + imm`. The result is held in a 2-entry skid buffer with valid/ready handshakes and a synchronous flush, so it can drive the ID/EX boundary directly.

---
 rtl/imm_gen_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: field extraction, sign extension and pc+imm,
// registered through a two-entry skid buffer with valid/ready on both sides.
module imm_gen_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [7:0]      in_ext_op,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : gBadXlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] immNew;
  logic [XLEN-1:0] targetNew;
  logic            illegalNew;
  logic            unusedOpcode;

  // Opcode bits never contribute to any immediate format.
  assign unusedOpcode = ^in_instr[6:0];

  always_comb begin
    immNew     = '0;
    illegalNew = 1'b0;
    unique case (in_ext_op)
      8'h01:   immNew = XLEN'(in_instr[24:20]);
      8'h02:   immNew = XLEN'($signed(in_instr[31:20]));
      8'h04:   immNew = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      8'h08:   immNew = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                       in_instr[11:8], 1'b0}));
      8'h10:   immNew = XLEN'($signed({in_instr[31:12], 12'b0}));
      8'h20:   immNew = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                       in_instr[30:21], 1'b0}));
      8'h40:   immNew = XLEN'(in_instr[19:15]);
      8'h80:   immNew = XLEN'(in_instr[25:20]);
      default: illegalNew = 1'b1;
    endcase
  end

  assign targetNew = in_pc + immNew;

  logic            mainValid_q, mainValid_d, skidValid_q, skidValid_d;
  logic [XLEN-1:0] mainImm_q, mainImm_d, skidImm_q, skidImm_d;
  logic [XLEN-1:0] mainTarget_q, mainTarget_d, skidTarget_q, skidTarget_d;
  logic            mainIllegal_q, mainIllegal_d, skidIllegal_q, skidIllegal_d;
  logic            accept, drain;

  assign in_ready = !skidValid_q && !rst;
  assign accept   = in_valid && in_ready;
  assign drain    = mainValid_q && out_ready;

  always_comb begin
    mainValid_d   = mainValid_q;
    mainImm_d     = mainImm_q;
    mainTarget_d  = mainTarget_q;
    mainIllegal_d = mainIllegal_q;
    skidValid_d   = skidValid_q;
    skidImm_d     = skidImm_q;
    skidTarget_d  = skidTarget_q;
    skidIllegal_d = skidIllegal_q;
    if (flush) begin
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else if (skidValid_q) begin
      // in_ready is low here, so only a skid-to-main move can happen.
      if (drain) begin
        mainValid_d   = 1'b1;
        mainImm_d     = skidImm_q;
        mainTarget_d  = skidTarget_q;
        mainIllegal_d = skidIllegal_q;
        skidValid_d   = 1'b0;
      end
    end else if (accept && (!mainValid_q || drain)) begin
      mainValid_d   = 1'b1;
      mainImm_d     = immNew;
      mainTarget_d  = targetNew;
      mainIllegal_d = illegalNew;
    end else if (accept) begin
      skidValid_d   = 1'b1;
      skidImm_d     = immNew;
      skidTarget_d  = targetNew;
      skidIllegal_d = illegalNew;
    end else if (drain) begin
      mainValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mainValid_q   <= 1'b0;
      mainImm_q     <= '0;
      mainTarget_q  <= '0;
      mainIllegal_q <= 1'b0;
      skidValid_q   <= 1'b0;
      skidImm_q     <= '0;
      skidTarget_q  <= '0;
      skidIllegal_q <= 1'b0;
    end else begin
      mainValid_q   <= mainValid_d;
      mainImm_q     <= mainImm_d;
      mainTarget_q  <= mainTarget_d;
      mainIllegal_q <= mainIllegal_d;
      skidValid_q   <= skidValid_d;
      skidImm_q     <= skidImm_d;
      skidTarget_q  <= skidTarget_d;
      skidIllegal_q <= skidIllegal_d;
    end
  end

  assign out_valid   = mainValid_q;
  assign out_imm     = mainImm_q;
  assign out_target  = mainTarget_q;
  assign out_illegal = mainIllegal_q;

endmodule
